// File: rtl/counter_checker_pkg.sv
// Shared types and the reference next-value model for the up/down counter checker.
package counter_checker_pkg;

  typedef enum logic [1:0] {StIdle, StArm, StRun} chk_state_e;

  localparam logic [1:0] ErrNone  = 2'b00;
  localparam logic [1:0] ErrReset = 2'b01;
  localparam logic [1:0] ErrHold  = 2'b10;
  localparam logic [1:0] ErrStep  = 2'b11;

  // Widest counter the model supports; results are masked to the requested width.
  localparam int unsigned MaxW = 32;

  function automatic logic [MaxW-1:0] next_count(input logic            rst,
                                                 input logic            en,
                                                 input logic            dir,
                                                 input logic [MaxW-1:0] val,
                                                 input int unsigned     width);
    logic [MaxW-1:0] mask;
    logic [MaxW-1:0] res;
    mask = (width >= MaxW) ? '1 : ((MaxW'(1) << width) - MaxW'(1));
    if (rst) begin
      res = '0;
    end else if (!en) begin
      res = val;
    end else if (dir) begin
      res = val + MaxW'(1);
    end else begin
      res = val - MaxW'(1);
    end
    return res & mask;
  endfunction

endpackage

// File: rtl/counter_checker.sv
// Transition monitor for an up/down counter: flags any sample that breaks the
// reset/hold/step rules and keeps a sticky flag, saturating count and first-error snapshot.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_en,
  input  logic             clear,
  input  logic             dut_rst,
  input  logic             enable,
  input  logic             dir,
  input  logic [WIDTH-1:0] counter_in,
  output logic             err,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got
);

  chk_state_e state_q, state_d;

  logic             prev_rst_q, prev_en_q, prev_dir_q;
  logic [WIDTH-1:0] prev_val_q;

  logic             err_q, err_d;
  logic             err_pulse_q, err_pulse_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [WIDTH-1:0] first_exp_q, first_exp_d;
  logic [WIDTH-1:0] first_got_q, first_got_d;

  logic            compare;
  logic            mismatch;
  logic [MaxW-1:0] exp_full;
  logic [1:0]      code_sel;

  assign exp_full = next_count(prev_rst_q, prev_en_q, prev_dir_q, MaxW'(prev_val_q), WIDTH);
  assign mismatch = compare && (MaxW'(counter_in) != exp_full);
  assign code_sel = prev_rst_q ? ErrReset : (!prev_en_q ? ErrHold : ErrStep);

  always_comb begin
    state_d = state_q;
    compare = 1'b0;
    if (clear) begin
      state_d = chk_en ? StArm : StIdle;
    end else begin
      case (state_q)
        StIdle: if (chk_en) state_d = StArm;
        StArm:  state_d = chk_en ? StRun : StIdle;
        StRun: begin
          if (chk_en) compare = 1'b1;
          else        state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    err_d       = err_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    err_count_d = err_count_q;
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;
    if (clear) begin
      err_d       = 1'b0;
      err_code_d  = ErrNone;
      err_count_d = '0;
      first_exp_d = '0;
      first_got_d = '0;
    end else if (mismatch) begin
      err_d       = 1'b1;
      err_pulse_d = 1'b1;
      err_code_d  = code_sel;
      if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
      if (!err_q) begin
        first_exp_d = exp_full[WIDTH-1:0];
        first_got_d = counter_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      prev_rst_q  <= 1'b0;
      prev_en_q   <= 1'b0;
      prev_dir_q  <= 1'b0;
      prev_val_q  <= '0;
      err_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ErrNone;
      err_count_q <= '0;
      first_exp_q <= '0;
      first_got_q <= '0;
    end else begin
      state_q <= state_d;
      // Always reload from the observed sample so one bad value yields one error.
      if (state_q != StIdle) begin
        prev_rst_q <= dut_rst;
        prev_en_q  <= enable;
        prev_dir_q <= dir;
        prev_val_q <= counter_in;
      end
      err_q       <= err_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
    end
  end

  assign err       = err_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;
  assign first_exp = first_exp_q;
  assign first_got = first_got_q;

endmodule

// File: tb/tb_counter_checker.sv
// Directed self-checking bench for counter_checker (WIDTH=8, CNT_W=8).
module tb_counter_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       chk_en;
  logic       clear;
  logic       dut_rst;
  logic       enable;
  logic       dir;
  logic [7:0] counter_in;
  logic       err;
  logic       err_pulse;
  logic [1:0] err_code;
  logic [7:0] err_count;
  logic [7:0] first_exp;
  logic [7:0] first_got;

  int errors = 0;
  int checks = 0;

  counter_checker #(.WIDTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .chk_en     (chk_en),
    .clear      (clear),
    .dut_rst    (dut_rst),
    .enable     (enable),
    .dir        (dir),
    .counter_in (counter_in),
    .err        (err),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .err_count  (err_count),
    .first_exp  (first_exp),
    .first_got  (first_got)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e, input logic p, input logic [1:0] c,
                           input logic [7:0] n, input logic [7:0] fe, input logic [7:0] fg);
    check({tag, ".err"},       32'(err),       32'(e));
    check({tag, ".err_pulse"}, 32'(err_pulse), 32'(p));
    check({tag, ".err_code"},  32'(err_code),  32'(c));
    check({tag, ".err_count"}, 32'(err_count), 32'(n));
    check({tag, ".first_exp"}, 32'(first_exp), 32'(fe));
    check({tag, ".first_got"}, 32'(first_got), 32'(fg));
  endtask

  // Present one sample, take the rising edge, then settle 1 time unit past it.
  task automatic step(input logic r, input logic e, input logic d, input logic [7:0] v);
    dut_rst    = r;
    enable     = e;
    dir        = d;
    counter_in = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; chk_en = 1'b0; clear = 1'b0;
    dut_rst = 1'b0; enable = 1'b0; dir = 1'b0; counter_in = 8'd0;
    #3;
    check_all("reset", 1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0);
    #4 rst = 1'b0;

    // Good count: reset twice, then count up 0..4
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'd33);  // IDLE -> ARM
    step(1'b1, 1'b0, 1'b0, 8'd77);  // ARM capture, no compare
    step(1'b1, 1'b1, 1'b1, 8'd0);
    step(1'b0, 1'b1, 1'b1, 8'd0);
    step(1'b0, 1'b1, 1'b1, 8'd1);
    step(1'b0, 1'b1, 1'b1, 8'd2);
    step(1'b0, 1'b1, 1'b1, 8'd3);
    step(1'b0, 1'b1, 1'b1, 8'd4);
    check_all("good", 1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0);

    // Wrap both ways: 254,255,0 up then 0,255,254 down
    step(1'b1, 1'b1, 1'b1, 8'd5);
    step(1'b0, 1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 8'd255);
    step(1'b0, 1'b1, 1'b0, 8'd254);
    step(1'b0, 1'b1, 1'b1, 8'd253);
    step(1'b0, 1'b1, 1'b1, 8'd254);
    step(1'b0, 1'b1, 1'b1, 8'd255);
    step(1'b0, 1'b1, 1'b1, 8'd0);
    step(1'b0, 1'b1, 1'b0, 8'd1);
    step(1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 8'd255);
    step(1'b0, 1'b1, 1'b0, 8'd254);
    check_all("wrap", 1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0);

    // Walk to 5 and hold, then a hold fault 5 -> 6
    step(1'b1, 1'b0, 1'b0, 8'd253);
    step(1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 8'd0);
    step(1'b0, 1'b1, 1'b1, 8'd1);
    step(1'b0, 1'b1, 1'b1, 8'd2);
    step(1'b0, 1'b1, 1'b1, 8'd3);
    step(1'b0, 1'b1, 1'b1, 8'd4);
    step(1'b0, 1'b0, 1'b0, 8'd5);
    check_all("pre_hold", 1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0);
    step(1'b0, 1'b0, 1'b0, 8'd6);
    check_all("hold_fault", 1'b1, 1'b1, 2'b10, 8'd1, 8'd5, 8'd6);
    step(1'b0, 1'b0, 1'b0, 8'd6);  // resynced on 6: no cascade
    check_all("hold_resync", 1'b1, 1'b0, 2'b10, 8'd1, 8'd5, 8'd6);

    // Reset fault: dut_rst seen with 7, next sample still 7
    step(1'b0, 1'b1, 1'b1, 8'd6);
    step(1'b1, 1'b0, 1'b0, 8'd7);
    check("pre_reset.err_pulse", 32'(err_pulse), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'd7);
    check_all("reset_fault", 1'b1, 1'b1, 2'b01, 8'd2, 8'd5, 8'd6);

    // Saturation: counter stuck at 7 while counting up
    step(1'b0, 1'b1, 1'b1, 8'd7);
    check("sat_entry.err_pulse", 32'(err_pulse), 32'd0);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'd7);
      check("sat.err_pulse", 32'(err_pulse), 32'd1);
      check("sat.err_count", 32'(err_count), (i + 3 > 255) ? 32'd255 : 32'(i + 3));
    end
    check_all("sat_end", 1'b1, 1'b1, 2'b11, 8'd255, 8'd5, 8'd6);

    // Clear beats a mismatching compare, then ARM skips its compare
    clear = 1'b1;
    step(1'b0, 1'b1, 1'b1, 8'd7);
    clear = 1'b0;
    check_all("clear", 1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 8'd100);
    check_all("arm_after_clear", 1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 8'd101);
    check("run_after_clear.err", 32'(err), 32'd0);

    // Edge seeing chk_en=0 performs no compare
    chk_en = 1'b0;
    step(1'b0, 1'b1, 1'b1, 8'd50);
    check("disable.err", 32'(err), 32'd0);

    // Re-enable, create an error, then async reset between edges
    chk_en = 1'b1;
    step(1'b0, 1'b1, 1'b1, 8'd50);
    step(1'b0, 1'b1, 1'b1, 8'd60);
    step(1'b0, 1'b1, 1'b1, 8'd70);
    check_all("rearm_fault", 1'b1, 1'b1, 2'b11, 8'd1, 8'd61, 8'd70);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
Hardware monitor that reads an up/down counter's control inputs and output every clock and checks each transition against the counter rules: reset to 0, hold when disabled, ±1 by direction, modulo 2^WIDTH. It sits alongside the counter in the design, or in a bench harness, and raises a sticky error flag with diagnostics. It is the consumer/reader end of the counter interface, the in-silicon counterpart of a bench self-check.

Parameters:
WIDTH, 8, bit width of the observed counter value
CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  checker reset; asynchronous, active-high
chk_en  in  1  checking enable; low = checker idle
clear  in  1  synchronous clear of all error state
dut_rst  in  1  observed counter reset (synchronous in the counter)
enable  in  1  observed counter enable
dir  in  1  observed direction; 1 = up, 0 = down
counter_in  in  WIDTH  observed counter_out
err  out  1  sticky error flag
err_pulse  out  1  one-cycle pulse per detected mismatch
err_code  out  2  code of the most recent error
err_count  out  CNT_W  saturating count of mismatches
first_exp  out  WIDTH  expected value at the first error
first_got  out  WIDTH  observed value at the first error

Behaviour:
- All outputs are registered. On rst (async) every output is 0 and the state is IDLE.
- Sample model:
  - At every rising edge k, the checker samples S_k = {dut_rst, enable, dir, counter_in}.
  - The required relation is counter_in(k+1) = exp(S_k), where exp = 0 if dut_rst; else counter_in if !enable; else counter_in+1 if dir; else counter_in-1.
  - Arithmetic is modulo 2^WIDTH: 2^WIDTH-1 up gives 0; 0 down gives 2^WIDTH-1. Wrap is never an error.
- States:
  - IDLE: no checks; prev registers are not loaded. Goes to ARM when chk_en=1.
  - ARM: captures S_k as prev with no compare. Goes to RUN next edge, or to IDLE if chk_en=0.
  - RUN: compares counter_in against exp(prev) every edge, then loads prev <= S_k. Goes to IDLE when chk_en=0; the edge that sees chk_en=0 performs no compare.
- Error codes, selected by the prev controls (mutually exclusive):
  - 2'b01 RESET_FAIL: prev dut_rst=1.
  - 2'b10 HOLD_FAIL: prev enable=0.
  - 2'b11 STEP_FAIL: otherwise.
  - 2'b00: no error yet.
- On a mismatch at edge k+1, registered at that same edge:
  - err_pulse=1 for exactly one cycle; err=1 sticky.
  - err_code updated.
  - err_count+1, saturating at 2^CNT_W-1.
  - first_exp/first_got loaded only when err was 0 before this edge.
- Re-sync rule: after a mismatch, the checker continues from the observed value. One bad value yields one error, not a cascade.
- clear (sync):
  - Takes priority over a compare on the same edge.
  - Zeroes err, err_pulse, err_code, err_count, first_exp, first_got.
  - State goes to ARM if chk_en=1, else IDLE.
- rst mid-operation forces IDLE and zero outputs immediately, without waiting for an edge.
- Simultaneous mismatch and saturation: err_count holds at max; err_pulse still fires.
- dut_rst high in consecutive samples: each following sample must be 0.

Decomposition:
- Package counter_checker_pkg holds:
  - State enum {IDLE, ARM, RUN}.
  - Error-code constants ERR_NONE/ERR_RESET/ERR_HOLD/ERR_STEP.
  - A pure function next_count(rst, en, dir, val) parameterised by width.
- No sub-module: the next-value model is the package function, reused by the bench scoreboard.

Test Plan:
- Good count: chk_en=1, dut_rst=1 for 2 cycles, then enable=1, dir=1, counter driven 0,1,2,3,4 -> err=0, err_count=0, err_code=00.
- Wrap: counter 254,255,0 with dir=1, then 0,255,254 with dir=0 -> no error.
- Hold fault: enable=0, counter 5 then 6 -> err_pulse high one cycle, err=1, err_code=10, first_exp=5, first_got=6, err_count=1; next sample 6 with enable=0 -> no further error.
- Reset fault: dut_rst=1 while counter=7, next sample 7 -> err_code=01, err_count increments; first_exp/first_got unchanged if already set, else 0/7.
- Saturation: 300 consecutive STEP_FAIL samples (dir=1, counter stuck) -> err_count=255, first_exp/first_got hold the first error only.
- Clear/reset: clear=1 -> all outputs 0; a mismatching sample on the following ARM edge raises no error. Asserting rst between edges -> outputs 0 before the next clk edge.
